// File: rtl/adc_spi_ser_if.sv
// Handshake and serial-bus bundle for the ADC SPI serializer.
// The master side requests frames; the slave side is the serializer itself.
interface adc_spi_ser_if #(
  parameter int NBITS = 24
);
  logic             start;
  logic [NBITS-1:0] data;
  logic [11:0]      cs_sel;
  logic [11:0]      mask;
  logic             busy;
  logic             done;
  logic             nosel;
  logic [11:0]      cs;
  logic             sclk;
  logic             sdata;

  modport master (
    output start, data, cs_sel, mask,
    input  busy, done, nosel, cs, sclk, sdata
  );

  modport slave (
    input  start, data, cs_sel, mask,
    output busy, done, nosel, cs, sclk, sdata
  );
endinterface

// File: rtl/adc_spi_ser.sv
// SPI frame serializer driving up to twelve ADCs with active-low chip selects.
// One accepted START shifts an NBITS frame MSB first; SCLK half-period is
// CLK_DIV system clocks. Every output comes straight from a register.
module adc_spi_ser #(
  parameter int CLK_DIV = 4,
  parameter int NBITS   = 24
) (
  input  logic clk,
  input  logic rst,          // synchronous, active-low
  adc_spi_ser_if.slave bus
);

  localparam int             BW       = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [7:0]     PH_LAST  = 8'(CLK_DIV - 1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(NBITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t           state;
  logic [7:0]       phase;
  logic [BW-1:0]    bit_cnt;
  logic [NBITS-1:0] shreg;
  logic [11:0]      cs_q;
  logic             sclk_q;
  logic             sdata_q;
  logic             busy_q;
  logic             done_q;
  logic             nosel_q;

  logic [11:0]      sel_eff;
  logic [NBITS-1:0] shreg_nxt;
  logic             phase_end;

  assign sel_eff   = bus.cs_sel & bus.mask;
  assign shreg_nxt = shreg << 1;
  assign phase_end = (phase == PH_LAST);

  // Transaction sequencer: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  // SDATA is reloaded only when SCLK falls, so it is stable across every
  // high phase. The frame shift register holds data only and is not reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      phase   <= 8'd0;
      bit_cnt <= '0;
      cs_q    <= 12'hFFF;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nosel_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            nosel_q <= (sel_eff == 12'h000);
            if (sel_eff == 12'h000) begin
              // Nothing to talk to: finish immediately without touching the bus.
              done_q <= 1'b1;
            end else begin
              cs_q    <= ~sel_eff;
              shreg   <= bus.data;
              sdata_q <= bus.data[NBITS-1];
              busy_q  <= 1'b1;
              phase   <= 8'd0;
              state   <= SETUP;
            end
          end
        end
        SETUP: begin
          if (phase_end) begin
            phase   <= 8'd0;
            bit_cnt <= '0;
            state   <= SHIFT;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        SHIFT: begin
          if (!phase_end) begin
            phase <= phase + 8'd1;
          end else begin
            phase <= 8'd0;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state <= HOLD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= shreg_nxt;
                sdata_q <= shreg_nxt[NBITS-1];
              end
            end
          end
        end
        HOLD: begin
          if (phase_end) begin
            phase   <= 8'd0;
            cs_q    <= 12'hFFF;
            sdata_q <= 1'b0;
            state   <= GAP;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        GAP: begin
          if (phase_end) begin
            phase  <= 8'd0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cs    = cs_q;
  assign bus.sclk  = sclk_q;
  assign bus.sdata = sdata_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.nosel = nosel_q;

endmodule

// File: tb/tb_adc_spi_ser.sv
// Bench for adc_spi_ser: a CLK_DIV=4 instance for single frames, selects,
// reset and ignored starts, plus a CLK_DIV=1 instance for streamed frames.
module tb_adc_spi_ser;

  localparam int NB       = 24;
  localparam int D        = 4;
  localparam int CS_LAST  = (2*NB + 2)*D;       // last cycle with CS asserted
  localparam int DONE_J   = (2*NB + 3)*D + 1;   // DONE cycle after T0
  localparam int RISE1    = 2*D + 1;            // first SCLK rising edge
  localparam int PERIOD1  = (2*NB + 3)*1 + 1;   // back-to-back period at D=1

  logic clk = 1'b0;
  logic rst = 1'b0;

  adc_spi_ser_if #(.NBITS(NB)) if0 ();
  adc_spi_ser_if #(.NBITS(NB)) if1 ();

  adc_spi_ser #(.CLK_DIV(D), .NBITS(NB)) u_dut (.clk(clk), .rst(rst), .bus(if0));
  adc_spi_ser #(.CLK_DIV(1), .NBITS(NB)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [NB-1:0] q0[$];
  logic [NB-1:0] q1[$];

  // Measurements gathered by observe()
  int          m_done_j, m_done_cnt, m_rises, m_first_rise, m_busy_cyc;
  int          m_cs_bad, m_sdata_bad, m_glitch, m_sclk_hi;
  logic [NB-1:0] m_bits;
  logic        m_nosel_done, m_nosel_end;
  logic [11:0] m_cs_rst;
  logic        m_sclk_rst, m_busy_rst;

  task automatic start_frame(input logic [NB-1:0] d, input logic [11:0] sel, input logic [11:0] msk);
    @(negedge clk);
    if0.start  = 1'b1;
    if0.data   = d;
    if0.cs_sel = sel;
    if0.mask   = msk;
    q0.push_back(d);
  endtask

  // Watches ncyc cycles after T0 on the CLK_DIV=4 instance. Inputs are
  // scrambled right after acceptance; optional extra START / reset pulses.
  task automatic observe(input logic [11:0] exp_cs, input int ncyc, input int extra_j, input int rst_j);
    logic ps, pd;
    ps = 1'b0; pd = 1'b0;
    m_done_j = -1; m_done_cnt = 0; m_rises = 0; m_first_rise = -1; m_busy_cyc = 0;
    m_cs_bad = 0; m_sdata_bad = 0; m_glitch = 0; m_sclk_hi = 0; m_bits = '0;
    m_nosel_done = 1'bx; m_cs_rst = 'x; m_sclk_rst = 1'bx; m_busy_rst = 1'bx;
    for (int j = 1; j <= ncyc; j++) begin
      @(negedge clk);
      if (if0.sclk && !ps) begin
        m_rises++;
        if (m_first_rise < 0) m_first_rise = j;
        m_bits = {m_bits[NB-2:0], if0.sdata};
      end
      if (if0.sclk) m_sclk_hi++;
      if (if0.sclk && ps && (if0.sdata !== pd)) m_glitch++;
      if (if0.busy) m_busy_cyc++;
      if (if0.done) begin
        m_done_cnt++;
        if (m_done_j < 0) begin
          m_done_j = j;
          m_nosel_done = if0.nosel;
        end
      end
      if (j == rst_j + 1) begin
        m_cs_rst = if0.cs; m_sclk_rst = if0.sclk; m_busy_rst = if0.busy;
      end
      if (rst_j < 0) begin
        if (if0.cs !== ((j <= CS_LAST) ? exp_cs : 12'hFFF)) m_cs_bad++;
        if (j > CS_LAST && if0.sdata !== 1'b0) m_sdata_bad++;
      end
      ps = if0.sclk; pd = if0.sdata;
      if (j == 1) begin
        if0.start  = 1'b0;
        if0.data   = NB'($urandom);
        if0.cs_sel = 12'($urandom);
        if0.mask   = 12'($urandom);
      end
      if (j == extra_j) if0.start = 1'b1;
      if (j == extra_j + 1) if0.start = 1'b0;
      if (j == rst_j) rst = 1'b0;
      if (j == rst_j + 1) rst = 1'b1;
    end
    m_nosel_end = if0.nosel;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0;
    if0.start = 1'b1; if0.data = 24'hFFFFFF; if0.cs_sel = 12'hFFF; if0.mask = 12'hFFF;
    repeat (3) @(negedge clk);
    n_total++; if (if0.cs !== 12'hFFF) $display("FAIL reset_cs: got %h want fff", if0.cs); else n_pass++;
    n_total++; if (if0.sclk !== 1'b0) $display("FAIL reset_sclk: got %b want 0", if0.sclk); else n_pass++;
    n_total++; if (if0.sdata !== 1'b0) $display("FAIL reset_sdata: got %b want 0", if0.sdata); else n_pass++;
    n_total++; if (if0.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", if0.busy); else n_pass++;
    n_total++; if (if0.done !== 1'b0) $display("FAIL reset_done: got %b want 0", if0.done); else n_pass++;
    n_total++; if (if0.nosel !== 1'b0) $display("FAIL reset_nosel: got %b want 0", if0.nosel); else n_pass++;
    rst = 1'b1;
    if0.start = 1'b0;
    @(negedge clk);
    n_total++; if (if0.busy !== 1'b0) $display("FAIL reset_priority_busy: got %b want 0", if0.busy); else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    logic [NB-1:0] e;
    start_frame(24'hA5C30F, 12'h001, 12'hFFF);
    observe(12'hFFE, DONE_J + 10, -1, -1);
    e = q0.pop_front();
    n_total++; if (m_done_j !== DONE_J) $display("FAIL basic_done_cycle: got %0d want %0d", m_done_j, DONE_J); else n_pass++;
    n_total++; if (m_done_cnt !== 1) $display("FAIL basic_done_count: got %0d want 1", m_done_cnt); else n_pass++;
    n_total++; if (m_rises !== NB) $display("FAIL basic_rises: got %0d want %0d", m_rises, NB); else n_pass++;
    n_total++; if (m_first_rise !== RISE1) $display("FAIL basic_first_rise: got %0d want %0d", m_first_rise, RISE1); else n_pass++;
    n_total++; if (m_bits !== e) $display("FAIL basic_bits: got %h want %h", m_bits, e); else n_pass++;
    n_total++; if (m_cs_bad !== 0) $display("FAIL basic_cs: got %0d bad cycles want 0", m_cs_bad); else n_pass++;
    n_total++; if (m_busy_cyc !== DONE_J - 1) $display("FAIL basic_busy: got %0d want %0d", m_busy_cyc, DONE_J - 1); else n_pass++;
    n_total++; if (m_glitch !== 0) $display("FAIL basic_sdata_stable: got %0d changes want 0", m_glitch); else n_pass++;
    n_total++; if (m_sdata_bad !== 0) $display("FAIL basic_sdata_idle: got %0d nonzero want 0", m_sdata_bad); else n_pass++;
    n_total++; if (m_nosel_done !== 1'b0) $display("FAIL basic_nosel: got %b want 0", m_nosel_done); else n_pass++;
  endtask

  task automatic test_nosel;
    start_frame(24'h123456, 12'h010, 12'h000);
    observe(12'hFFF, 20, -1, -1);
    void'(q0.pop_front());
    n_total++; if (m_done_j !== 1) $display("FAIL nosel_done_cycle: got %0d want 1", m_done_j); else n_pass++;
    n_total++; if (m_done_cnt !== 1) $display("FAIL nosel_done_count: got %0d want 1", m_done_cnt); else n_pass++;
    n_total++; if (m_nosel_done !== 1'b1) $display("FAIL nosel_flag: got %b want 1", m_nosel_done); else n_pass++;
    n_total++; if (m_nosel_end !== 1'b1) $display("FAIL nosel_held: got %b want 1", m_nosel_end); else n_pass++;
    n_total++; if (m_busy_cyc !== 0) $display("FAIL nosel_busy: got %0d want 0", m_busy_cyc); else n_pass++;
    n_total++; if (m_sclk_hi !== 0) $display("FAIL nosel_sclk: got %0d high cycles want 0", m_sclk_hi); else n_pass++;
    n_total++; if (m_cs_bad !== 0) $display("FAIL nosel_cs: got %0d bad cycles want 0", m_cs_bad); else n_pass++;
  endtask

  task automatic test_mask;
    logic [NB-1:0] e;
    start_frame(24'h5A0FF1, 12'h003, 12'hFFE);
    observe(12'hFFD, DONE_J + 5, -1, -1);
    e = q0.pop_front();
    n_total++; if (m_cs_bad !== 0) $display("FAIL mask_cs: got %0d bad cycles want 0", m_cs_bad); else n_pass++;
    n_total++; if (m_nosel_done !== 1'b0) $display("FAIL mask_nosel: got %b want 0", m_nosel_done); else n_pass++;
    n_total++; if (m_bits !== e) $display("FAIL mask_bits: got %h want %h", m_bits, e); else n_pass++;
    n_total++; if (m_done_j !== DONE_J) $display("FAIL mask_done_cycle: got %0d want %0d", m_done_j, DONE_J); else n_pass++;
  endtask

  task automatic test_ignore_start;
    logic [NB-1:0] e;
    start_frame(24'h0F1E2D, 12'h800, 12'hFFF);
    observe(12'h7FF, DONE_J + 50, 50, -1);
    e = q0.pop_front();
    n_total++; if (m_rises !== NB) $display("FAIL ignore_rises: got %0d want %0d", m_rises, NB); else n_pass++;
    n_total++; if (m_done_cnt !== 1) $display("FAIL ignore_done_count: got %0d want 1", m_done_cnt); else n_pass++;
    n_total++; if (m_done_j !== DONE_J) $display("FAIL ignore_done_cycle: got %0d want %0d", m_done_j, DONE_J); else n_pass++;
    n_total++; if (m_bits !== e) $display("FAIL ignore_bits: got %h want %h", m_bits, e); else n_pass++;
  endtask

  task automatic test_reset_mid;
    logic [NB-1:0] e;
    // Reset lands in the high phase of bit 10, after its rising edge.
    start_frame(24'hC0FFEE, 12'hFFF, 12'hFFF);
    observe(12'h000, DONE_J + 10, -1, 90);
    void'(q0.pop_front());   // aborted frame is discarded
    n_total++; if (m_cs_rst !== 12'hFFF) $display("FAIL rstmid_cs: got %h want fff", m_cs_rst); else n_pass++;
    n_total++; if (m_sclk_rst !== 1'b0) $display("FAIL rstmid_sclk: got %b want 0", m_sclk_rst); else n_pass++;
    n_total++; if (m_busy_rst !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", m_busy_rst); else n_pass++;
    n_total++; if (m_done_cnt !== 0) $display("FAIL rstmid_no_done: got %0d want 0", m_done_cnt); else n_pass++;
    n_total++; if (m_rises !== 11) $display("FAIL rstmid_rises: got %0d want 11", m_rises); else n_pass++;
    start_frame(NB'($urandom), 12'h440, 12'h0FF);
    observe(12'hFBF, DONE_J + 5, -1, -1);
    e = q0.pop_front();
    n_total++; if (m_done_j !== DONE_J) $display("FAIL rstmid_next_done: got %0d want %0d", m_done_j, DONE_J); else n_pass++;
    n_total++; if (m_bits !== e) $display("FAIL rstmid_next_bits: got %h want %h", m_bits, e); else n_pass++;
    n_total++; if (m_cs_bad !== 0) $display("FAIL rstmid_next_cs: got %0d bad cycles want 0", m_cs_bad); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int frames, last_done, rises, cs_run;
    logic seen_low, gap_pending, ps;
    logic [NB-1:0] bits, e;
    frames = 0; last_done = 0; rises = 0; cs_run = 0;
    seen_low = 1'b0; gap_pending = 1'b0; ps = 1'b0; bits = '0;
    @(negedge clk);
    if1.start = 1'b1; if1.cs_sel = 12'hFFF; if1.mask = 12'hFFF;
    if1.data = NB'($urandom);
    q1.push_back(if1.data);
    for (int j = 1; j <= 4*PERIOD1 + 40 && frames < 4; j++) begin
      @(negedge clk);
      if (if1.sclk && !ps) begin
        rises++;
        bits = {bits[NB-2:0], if1.sdata};
      end
      ps = if1.sclk;
      if (if1.cs !== 12'hFFF) begin
        if (gap_pending) begin
          n_total++; if (cs_run !== 2) $display("FAIL b2b_cs_gap: got %0d want 2", cs_run); else n_pass++;
          gap_pending = 1'b0;
        end
        cs_run = 0;
        seen_low = 1'b1;
      end else if (seen_low) begin
        cs_run++;
        gap_pending = 1'b1;
      end
      if (if1.done) begin
        frames++;
        e = q1.pop_front();
        n_total++; if (j - last_done !== PERIOD1) $display("FAIL b2b_period: got %0d want %0d", j - last_done, PERIOD1); else n_pass++;
        n_total++; if (rises !== NB) $display("FAIL b2b_rises: got %0d want %0d", rises, NB); else n_pass++;
        n_total++; if (bits !== e) $display("FAIL b2b_bits: got %h want %h", bits, e); else n_pass++;
        n_total++; if (if1.busy !== 1'b0) $display("FAIL b2b_busy_at_done: got %b want 0", if1.busy); else n_pass++;
        last_done = j; rises = 0; bits = '0;
        if (frames < 4) begin
          if1.data = NB'($urandom);
          q1.push_back(if1.data);
        end else begin
          if1.start = 1'b0;
        end
      end
    end
    if1.start = 1'b0;
    n_total++; if (frames !== 4) $display("FAIL b2b_frames: got %0d want 4", frames); else n_pass++;
  endtask

  initial begin
    if0.start = 1'b0; if0.data = '0; if0.cs_sel = '0; if0.mask = '0;
    if1.start = 1'b0; if1.data = '0; if1.cs_sel = '0; if1.mask = '0;
    test_reset();
    test_basic();
    test_nosel();
    test_mask();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
